key_lifecycle_sequencer: RTL and testbench
==========================================

# key_lifecycle_sequencer

Sequences the secure key lifecycle around the KDF and the secure key distributor: it starts key derivation, enables distribution, and watches for keys to become active. It arbitrates zeroization requests from software, the tamper sensor and its own key-loss/timeout detection, and retries failed provisioning a bounded number of times. It sits between the secure controller and the KDF/distributor pair, and it has no data path: it never touches key material, only handshakes and status.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles spent in KDF_WAIT or DIST before a timeout (≥4)
- MAX_RETRIES, 3: timeouts tolerated before FAULT (0..15)
- ZEROIZE_HOLD, 4: cycles zeroize_keys is held per zeroization (≥2)
- clock  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-high
- provision_req  in  1  start provisioning; sampled only in IDLE
- sw_zeroize_req  in  1  software zeroize request, level-sampled
- tamper_alert  in  1  tamper sensor, highest priority
- fault_clear  in  1  leave FAULT; ignored in other states
- kdf_start  out  1  one-cycle pulse to KDF
- kdf_keys_valid  in  1  KDF output keys valid
- enable_distribution  out  1  level to distributor, high only in DIST
- keys_distributed  in  1  distributor in ACTIVE
- keys_active  in  1  distributor ACTIVE and integrity OK
- zeroize_keys  out  1  zeroize command to distributor
- ready  out  1  keys provisioned and active
- busy  out  1  provisioning or zeroization in progress
- fault  out  1  unrecoverable; keys held zeroized
- retry_count  out  4  timeouts since last accepted provision_req
- zeroize_cause  out  2  last zeroize: 00 timeout, 01 software, 10 tamper, 11 key loss

## Operation
- States: IDLE, KDF_REQ, KDF_WAIT, DIST, READY, ZEROIZE, FAULT. All outputs are decoded from registered state/counters (Moore).
- IDLE: provision_req=1 -> KDF_REQ; retry_count cleared on that edge.
- KDF_REQ: kdf_start=1 for exactly this cycle -> KDF_WAIT; timer cleared.
- KDF_WAIT: kdf_keys_valid=1 -> DIST, timer cleared; else timer++.
- DIST: enable_distribution=1; keys_distributed=1 -> READY; else timer++.
- Timeout: in KDF_WAIT/DIST with timer==TIMEOUT_CYCLES-1 and the exit condition false. If retry_count<MAX_RETRIES: retry_count++, retry_pending=1, cause=00 -> ZEROIZE. Else -> FAULT.
- READY: ready=1. keys_active=0 -> ZEROIZE, cause=11, retry_pending=0.
- ZEROIZE: zeroize_keys=1; hold counter runs ZEROIZE_HOLD cycles. At the last hold cycle: if keys_distributed=1 -> FAULT; else if retry_pending -> KDF_REQ; else -> IDLE. retry_pending is cleared on exit.
- FAULT: zeroize_keys=1 and fault=1 continuously. fault_clear=1 -> IDLE with retry_count=0 and cause unchanged.
- Zeroize arbitration, evaluated every cycle ahead of normal transitions:
  - tamper_alert in any state except FAULT: -> ZEROIZE (re-entered if already there, hold counter restarts), cause=10, retry_pending=0.
  - Else sw_zeroize_req in IDLE/KDF_REQ/KDF_WAIT/DIST/READY: -> ZEROIZE, cause=01, retry_pending=0.
  - Both inputs together: cause=10.
  - Either input coincident with a timeout or key loss: the request wins.
  - sw_zeroize_req during ZEROIZE is ignored.
- busy=1 in KDF_REQ, KDF_WAIT, DIST, ZEROIZE. ready is 1 only in READY, fault only in FAULT.
- Timer width is clog2(TIMEOUT_CYCLES). It cannot overflow because the timeout exits first.

## Timing
- Reset values: state=IDLE; kdf_start, enable_distribution, zeroize_keys, ready, busy, fault all 0; retry_count=0; zeroize_cause=00; timer, hold counter and retry_pending 0. Reset applied mid-operation overrides every state, FAULT included.
- provision_req high at edge N: kdf_start high for cycle N+1 only; KDF_WAIT from N+2.
- kdf_keys_valid sampled at edge M: enable_distribution high from M+1.
- keys_distributed sampled at edge P: ready high from P+1 and enable_distribution low from P+1.
- Timeout edge T: zeroize_keys high for cycles T+1..T+ZEROIZE_HOLD; kdf_start at T+ZEROIZE_HOLD+1 on retry.
- Tamper sampled at edge Z: zeroize_keys high from Z+1, with ready/enable_distribution low in the same cycle.

## Test plan
- Happy path: provision_req 1 cycle; kdf_keys_valid 3 cycles later; keys_distributed 3 cycles after enable_distribution -> one kdf_start pulse, ready=1, retry_count=0, zeroize_keys never asserted.
- Retry then success (TIMEOUT_CYCLES=16, MAX_RETRIES=3): first KDF attempt silent -> timeout at 16 cycles, zeroize_keys exactly 4 cycles, cause=00, retry_count=1, second kdf_start; KDF answers the second attempt -> ready=1.
- Retry exhaustion: KDF never responds -> 4 kdf_start pulses, then FAULT with zeroize_keys held high and retry_count=3. fault_clear -> IDLE, retry_count=0.
- Key loss: in READY, drop keys_active while keys_distributed=1 for one cycle, then keys_distributed falls -> ZEROIZE, cause=11, then IDLE with ready=0.
- Arbitration: tamper_alert and sw_zeroize_req together in DIST -> cause=10. A second tamper_alert on hold cycle 3 restarts the hold, giving 7 total zeroize_keys cycles.
- Stuck distributor: keys_distributed stays 1 through the whole zeroize hold -> FAULT. A synchronous reset in FAULT returns every output to its reset value on the next cycle.

Source files
------------

// File: rtl/key_lifecycle_sequencer.sv
// Key lifecycle control FSM: drives KDF start, distribution enable and zeroization,
// arbitrates tamper/software/internal zeroize sources and bounds provisioning retries.
module key_lifecycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned ZEROIZE_HOLD   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       provision_req,
    input  logic       sw_zeroize_req,
    input  logic       tamper_alert,
    input  logic       fault_clear,
    output logic       kdf_start,
    input  logic       kdf_keys_valid,
    output logic       enable_distribution,
    input  logic       keys_distributed,
    input  logic       keys_active,
    output logic       zeroize_keys,
    output logic       ready,
    output logic       busy,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [1:0] zeroize_cause
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned HW = $clog2(ZEROIZE_HOLD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(ZEROIZE_HOLD - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b00;
    localparam logic [1:0] CAUSE_SOFTWARE = 2'b01;
    localparam logic [1:0] CAUSE_TAMPER   = 2'b10;
    localparam logic [1:0] CAUSE_KEY_LOSS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KDF_REQ,
        S_KDF_WAIT,
        S_DIST,
        S_READY,
        S_ZEROIZE,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    retry_q, retry_d;
    logic [1:0]    cause_q, cause_d;
    logic          pending_q, pending_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            hold_q    <= '0;
            retry_q   <= '0;
            cause_q   <= CAUSE_TIMEOUT;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            retry_q   <= retry_d;
            cause_q   <= cause_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hold_d    = hold_q;
        retry_d   = retry_q;
        cause_d   = cause_q;
        pending_d = pending_q;

        unique case (state_q)
            S_IDLE: begin
                if (provision_req) begin
                    state_d = S_KDF_REQ;
                    retry_d = '0;
                end
            end
            S_KDF_REQ: begin
                state_d = S_KDF_WAIT;
                timer_d = '0;
            end
            S_KDF_WAIT, S_DIST: begin
                if ((state_q == S_KDF_WAIT) && kdf_keys_valid) begin
                    state_d = S_DIST;
                    timer_d = '0;
                end else if ((state_q == S_DIST) && keys_distributed) begin
                    state_d = S_READY;
                end else if (timer_q == TIMER_LAST) begin
                    // Timeout: retry through a zeroize pass while budget remains
                    if (retry_q < RETRY_MAX) begin
                        state_d   = S_ZEROIZE;
                        hold_d    = '0;
                        retry_d   = retry_q + 4'd1;
                        pending_d = 1'b1;
                        cause_d   = CAUSE_TIMEOUT;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_READY: begin
                if (!keys_active) begin
                    state_d   = S_ZEROIZE;
                    hold_d    = '0;
                    cause_d   = CAUSE_KEY_LOSS;
                    pending_d = 1'b0;
                end
            end
            S_ZEROIZE: begin
                if (hold_q == HOLD_LAST) begin
                    pending_d = 1'b0;
                    if (keys_distributed) begin
                        state_d = S_FAULT;
                    end else if (pending_q) begin
                        state_d = S_KDF_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_FAULT: begin
                if (fault_clear) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // External zeroize requests override whatever the state logic chose
        if (tamper_alert && (state_q != S_FAULT)) begin
            state_d   = S_ZEROIZE;
            hold_d    = '0;
            cause_d   = CAUSE_TAMPER;
            pending_d = 1'b0;
        end else if (sw_zeroize_req && (state_q != S_FAULT) && (state_q != S_ZEROIZE)) begin
            state_d   = S_ZEROIZE;
            hold_d    = '0;
            cause_d   = CAUSE_SOFTWARE;
            pending_d = 1'b0;
        end
    end

    assign kdf_start           = (state_q == S_KDF_REQ);
    assign enable_distribution = (state_q == S_DIST);
    assign zeroize_keys        = (state_q == S_ZEROIZE) || (state_q == S_FAULT);
    assign ready               = (state_q == S_READY);
    assign fault               = (state_q == S_FAULT);
    assign busy                = (state_q == S_KDF_REQ) || (state_q == S_KDF_WAIT) ||
                                 (state_q == S_DIST)    || (state_q == S_ZEROIZE);
    assign retry_count         = retry_q;
    assign zeroize_cause       = cause_q;

endmodule

// File: tb/tb_key_lifecycle_sequencer.sv
// Directed bench for key_lifecycle_sequencer: per-cycle expected output vectors are
// queued with each stimulus step and compared once the DUT has clocked.
module tb_key_lifecycle_sequencer;

    localparam int TO   = 16;
    localparam int MAXR = 3;
    localparam int HOLD = 4;

    localparam int K_IDLE = 0;
    localparam int K_REQ  = 1;
    localparam int K_WAIT = 2;
    localparam int K_DIST = 3;
    localparam int K_RDY  = 4;
    localparam int K_ZER  = 5;
    localparam int K_FLT  = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       provision_req, sw_zeroize_req, tamper_alert, fault_clear;
    logic       kdf_keys_valid, keys_distributed, keys_active;
    logic       kdf_start, enable_distribution, zeroize_keys, ready, busy, fault;
    logic [3:0] retry_count;
    logic [1:0] zeroize_cause;

    key_lifecycle_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MAXR),
        .ZEROIZE_HOLD  (HOLD)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .provision_req      (provision_req),
        .sw_zeroize_req     (sw_zeroize_req),
        .tamper_alert       (tamper_alert),
        .fault_clear        (fault_clear),
        .kdf_start          (kdf_start),
        .kdf_keys_valid     (kdf_keys_valid),
        .enable_distribution(enable_distribution),
        .keys_distributed   (keys_distributed),
        .keys_active        (keys_active),
        .zeroize_keys       (zeroize_keys),
        .ready              (ready),
        .busy               (busy),
        .fault              (fault),
        .retry_count        (retry_count),
        .zeroize_cause      (zeroize_cause)
    );

    always #5 clock = ~clock;

    // {kdf_start, enable_distribution, zeroize_keys, ready, busy, fault, retry_count, zeroize_cause}
    logic [11:0] obs;
    assign obs = {kdf_start, enable_distribution, zeroize_keys, ready, busy, fault,
                  retry_count, zeroize_cause};

    string       tag_q[$];
    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [11:0] st(input int k, input int r, input int c);
        logic [5:0] f;
        case (k)
            K_IDLE:  f = 6'b000000;
            K_REQ:   f = 6'b100010;
            K_WAIT:  f = 6'b000010;
            K_DIST:  f = 6'b010010;
            K_RDY:   f = 6'b000100;
            K_ZER:   f = 6'b001010;
            K_FLT:   f = 6'b001001;
            default: f = 6'b111111;
        endcase
        return {f, 4'(r), 2'(c)};
    endfunction

    task automatic step(input string tag, input logic [11:0] e);
        string       t;
        logic [11:0] x;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        n_checks++;
        assert (obs === x) n_pass++;
        else $error("FAIL %s: observed %b required %b", t, obs, x);
    endtask

    initial begin
        reset = 1'b1;
        provision_req = 0; sw_zeroize_req = 0; tamper_alert = 0; fault_clear = 0;
        kdf_keys_valid = 0; keys_distributed = 0; keys_active = 0;
        step("reset", st(K_IDLE, 0, 0));
        step("reset", st(K_IDLE, 0, 0));
        reset = 1'b0;
        step("idle", st(K_IDLE, 0, 0));

        // Happy path
        provision_req = 1;
        step("happy_kdf_start", st(K_REQ, 0, 0));
        provision_req = 0;
        step("happy_wait", st(K_WAIT, 0, 0));
        step("happy_wait", st(K_WAIT, 0, 0));
        kdf_keys_valid = 1;
        step("happy_dist", st(K_DIST, 0, 0));
        kdf_keys_valid = 0;
        step("happy_dist", st(K_DIST, 0, 0));
        step("happy_dist", st(K_DIST, 0, 0));
        keys_distributed = 1; keys_active = 1;
        step("happy_ready", st(K_RDY, 0, 0));
        step("happy_ready", st(K_RDY, 0, 0));

        // Key loss while keys_distributed still high for one cycle
        keys_active = 0;
        step("keyloss_zer", st(K_ZER, 0, 3));
        keys_distributed = 0;
        for (int i = 0; i < HOLD - 1; i++) step("keyloss_zer", st(K_ZER, 0, 3));
        step("keyloss_idle", st(K_IDLE, 0, 3));

        // Retry then success
        provision_req = 1;
        step("retry_kdf_start1", st(K_REQ, 0, 3));
        provision_req = 0;
        for (int i = 0; i < TO; i++) step("retry_wait1", st(K_WAIT, 0, 3));
        for (int i = 0; i < HOLD; i++) step("retry_zer", st(K_ZER, 1, 0));
        step("retry_kdf_start2", st(K_REQ, 1, 0));
        step("retry_wait2", st(K_WAIT, 1, 0));
        kdf_keys_valid = 1;
        step("retry_dist", st(K_DIST, 1, 0));
        kdf_keys_valid = 0; keys_distributed = 1; keys_active = 1;
        step("retry_ready", st(K_RDY, 1, 0));

        // Software zeroize from READY; repeated request during hold is ignored
        sw_zeroize_req = 1;
        step("sw_zer", st(K_ZER, 1, 1));
        keys_distributed = 0; keys_active = 0;
        step("sw_zer_ignored", st(K_ZER, 1, 1));
        sw_zeroize_req = 0;
        step("sw_zer", st(K_ZER, 1, 1));
        step("sw_zer", st(K_ZER, 1, 1));
        step("sw_idle", st(K_IDLE, 1, 1));

        // Arbitration: tamper + software together in DIST, then tamper re-trigger
        provision_req = 1;
        step("arb_kdf_start", st(K_REQ, 0, 1));
        provision_req = 0;
        step("arb_wait", st(K_WAIT, 0, 1));
        kdf_keys_valid = 1;
        step("arb_dist", st(K_DIST, 0, 1));
        kdf_keys_valid = 0; tamper_alert = 1; sw_zeroize_req = 1;
        step("arb_tamper_zer", st(K_ZER, 0, 2));
        tamper_alert = 0; sw_zeroize_req = 0;
        step("arb_zer", st(K_ZER, 0, 2));
        step("arb_zer", st(K_ZER, 0, 2));
        tamper_alert = 1;
        step("arb_retamper", st(K_ZER, 0, 2));
        tamper_alert = 0;
        for (int i = 0; i < HOLD - 1; i++) step("arb_zer_restart", st(K_ZER, 0, 2));
        step("arb_idle", st(K_IDLE, 0, 2));

        // Retry exhaustion -> FAULT
        provision_req = 1;
        step("exh_kdf_start", st(K_REQ, 0, 2));
        provision_req = 0;
        for (int a = 0; a <= MAXR; a++) begin
            if (a > 0) step("exh_kdf_start", st(K_REQ, a, 0));
            for (int i = 0; i < TO; i++) step("exh_wait", st(K_WAIT, a, (a == 0) ? 2 : 0));
            if (a < MAXR)
                for (int i = 0; i < HOLD; i++) step("exh_zer", st(K_ZER, a + 1, 0));
        end
        step("exh_fault", st(K_FLT, MAXR, 0));
        tamper_alert = 1; sw_zeroize_req = 1;
        step("fault_ignores_req", st(K_FLT, MAXR, 0));
        tamper_alert = 0; sw_zeroize_req = 0;
        step("fault_hold", st(K_FLT, MAXR, 0));
        fault_clear = 1;
        step("fault_clear", st(K_IDLE, 0, 0));
        fault_clear = 0;

        // Stuck distributor through hold -> FAULT, then reset
        provision_req = 1;
        step("stuck_kdf_start", st(K_REQ, 0, 0));
        provision_req = 0;
        step("stuck_wait", st(K_WAIT, 0, 0));
        kdf_keys_valid = 1;
        step("stuck_dist", st(K_DIST, 0, 0));
        kdf_keys_valid = 0; keys_distributed = 1; keys_active = 1;
        step("stuck_ready", st(K_RDY, 0, 0));
        sw_zeroize_req = 1;
        step("stuck_zer", st(K_ZER, 0, 1));
        sw_zeroize_req = 0;
        for (int i = 0; i < HOLD - 1; i++) step("stuck_zer", st(K_ZER, 0, 1));
        step("stuck_fault", st(K_FLT, 0, 1));
        reset = 1;
        step("reset_in_fault", st(K_IDLE, 0, 0));
        reset = 0; keys_distributed = 0; keys_active = 0;
        step("post_reset_idle", st(K_IDLE, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
